eject_port_sync: RTL
====================

Name: eject_port_sync

Overview:
- Clocked local ejection port that sits directly downstream of the router input-port stage.
- Accepts NIN two-phase bundled-data channels (one per input port, with per-port packet-enable and tail-passed signals).
- Arbitrates round-robin at packet granularity (wormhole lock) and delivers flits to the local core over a clocked valid/ready interface through a 2-entry buffer.
- Forms the GALS boundary between the asynchronous router fabric and the synchronous core.

Parameters:
- WIDTH, 32, flit width in bits. Bits [WIDTH-1:WIDTH-2] carry the flit type: 01 head, 00 body, 10 tail, 11 single (head+tail).
- NIN, 4, number of upstream input ports feeding this output.
- SYNC_STAGES, 2, number of synchronizer flops on each req_i and PacketEnable_i (minimum 2).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req_i  in  NIN  two-phase request toggles from the input ports
- Data_i  in  NIN x WIDTH  bundled data; stable from a req_i toggle until the matching ack_o toggle
- ack_o  out  NIN  two-phase acknowledge toggles
- PacketEnable_i  in  NIN  level; high while input port i holds a packet routed here
- Tailpassed_o  out  NIN  two-phase toggle, one per completed packet
- out_valid_o  out  1  flit available to the core
- out_data_o  out  WIDTH  flit at the buffer head
- out_tail_o  out  1  head flit type is tail or single
- out_ready_i  in  1  core accepts the flit

Behaviour:
- Reset (synchronous, active-high, applies to all state):
  - Synchronizers cleared to 0; ack_o=0; Tailpassed_o=0.
  - FIFO emptied: out_valid_o=0, out_data_o=0, out_tail_o=0.
  - FSM to IDLE; last_grant=NIN-1, so port 0 has first priority.
  - Reset mid-packet drops the lock and any buffered flits. Upstream is reset by the same net.
- Synchronization:
  - req_s[i] is req_i[i] after SYNC_STAGES flops; en_s[i] is PacketEnable_i[i] after SYNC_STAGES flops.
  - pending[i] = req_s[i] XOR ack_o[i].
  - Data_i is sampled only while pending[owner]=1. The bundled-data delay is covered by the synchronizer latency.
- space = (count<2) OR (count==2 AND out_valid_o AND out_ready_i).
- FSM IDLE:
  - Candidate ports: en_s[i]=1.
  - Grant the first candidate searching from last_grant+1 modulo NIN.
  - owner := grant; go to LOCKED next cycle. No flit is captured in the grant cycle.
  - No candidate: stay in IDLE.
- FSM LOCKED(owner):
  - When pending[owner] AND space: push Data_i[owner] into the FIFO and toggle ack_o[owner] at the same edge.
  - If the captured type is tail or single: also toggle Tailpassed_o[owner] at that edge, set last_grant := owner, go to IDLE.
  - Otherwise stay LOCKED.
  - Non-owner pending requests are never acknowledged.
  - en_s[owner] dropping before the tail has no effect; the lock is held until the tail.
- Latency:
  - req_i toggle to ack_o toggle: at least SYNC_STAGES+1 cycles when already LOCKED and space is available.
  - Captured flit appears on out_valid_o the cycle after the push.
- FIFO (2 entries):
  - Push and pop in the same cycle are both honoured.
  - No push occurs when full without a pop; the ack is withheld, which back-pressures the async channel.
  - out_data_o and out_tail_o are held stable while out_valid_o=1 and out_ready_i=0.
- Flit type is not checked in IDLE. A body flit arriving first is forwarded under the lock like any other non-tail flit.
- Only one ack_o bit and at most one Tailpassed_o bit toggle per cycle.

Test Plan:
- Single flit, port 2:
  - Stimulus: PacketEnable_i=0100; Data_i[2]=0xC0000005 (type 11); toggle req_i[2]; out_ready_i=1.
  - Required: one flit out with out_data_o=0xC0000005, out_tail_o=1; ack_o[2] and Tailpassed_o[2] toggle once each; FSM returns to IDLE.
- Three-flit packet on port 0 with back-pressure:
  - Stimulus: flits 0x40000001, 0x00000002, 0x80000003; out_ready_i=0 throughout.
  - Required: two flits captured, third ack withheld. Raising out_ready_i releases all three in order; Tailpassed_o[0] toggles only with the third.
- Simultaneous requesters:
  - Stimulus: ports 1 and 3 both enabled with single-flit packets after reset.
  - Required: grant order 1 then 3. A second round with ports 3 and 1 enabled grants 1 then 3 again, since last_grant=3.
- Lock hold:
  - Stimulus: port 0 mid-packet (head sent) while port 1 toggles req_i[1].
  - Required: ack_o[1] unchanged until the port 0 tail passes; port 1 is then granted.
- Reset mid-packet:
  - Stimulus: assert reset after the head flit is buffered.
  - Required: the next cycle shows out_valid_o=0, ack_o=0, Tailpassed_o=0, FSM in IDLE; a fresh packet is then accepted normally.
- Push/pop same cycle:
  - Stimulus: FIFO full, out_ready_i=1, and pending[owner]=1.
  - Required: the pop and the push occur in the same cycle and count stays 2.

Source files
------------

// File: rtl/eject_port_sync_if.sv
// Bus bundle for the local ejection port.
// Upstream side: per-port two-phase req/ack channels with bundled data, per-port
// packet-enable levels and tail-passed toggles.
// Core side: clocked valid/ready flit stream.
// Modports: master (upstream/core stimulus) and slave (the ejection port itself).
interface eject_port_sync_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NIN   = 4
);
  logic [NIN-1:0]            req;
  logic [NIN-1:0][WIDTH-1:0] data;
  logic [NIN-1:0]            ack;
  logic [NIN-1:0]            packet_enable;
  logic [NIN-1:0]            tailpassed;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic                      out_tail;
  logic                      out_ready;

  modport master (
    output req, data, packet_enable, out_ready,
    input  ack, tailpassed, out_valid, out_data, out_tail
  );

  modport slave (
    input  req, data, packet_enable, out_ready,
    output ack, tailpassed, out_valid, out_data, out_tail
  );
endinterface

// File: rtl/eject_port_sync.sv
// Clocked local ejection port: GALS boundary between the asynchronous router
// fabric and the synchronous core.
// Ports:
//   clk   - core clock
//   reset - synchronous, active-high reset of all state
//   bus   - slave side of eject_port_sync_if:
//           req/data/ack      two-phase bundled-data channels, one per input port
//           packet_enable     level, port holds a packet routed here
//           tailpassed        two-phase toggle per completed packet
//           out_valid/out_data/out_tail/out_ready  valid/ready flit stream to the core
// Packets are arbitrated round-robin and locked (wormhole) until the tail flit,
// then buffered in a 2-entry FIFO.
module eject_port_sync #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NIN         = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              reset,
  eject_port_sync_if.slave bus
);

  localparam int unsigned IdxW = (NIN > 1) ? $clog2(NIN) : 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  // Synchronizer chains; index 0 is the first stage.
  logic [SYNC_STAGES-1:0][NIN-1:0] req_sync_q, req_sync_d;
  logic [SYNC_STAGES-1:0][NIN-1:0] en_sync_q, en_sync_d;
  logic [NIN-1:0]                  req_s, en_s, pending;

  state_e                          state_q, state_d;
  logic [IdxW-1:0]                 owner_q, owner_d;
  logic [IdxW-1:0]                 last_grant_q, last_grant_d;
  logic [NIN-1:0]                  ack_q, ack_d;
  logic [NIN-1:0]                  tailp_q, tailp_d;

  logic [1:0][WIDTH-1:0]           mem_q, mem_d;
  logic                            rd_ptr_q, rd_ptr_d;
  logic                            wr_ptr_q, wr_ptr_d;
  logic [1:0]                      count_q, count_d;

  logic                            found;
  logic [IdxW-1:0]                 grant, idx;
  logic [WIDTH-1:0]                own_flit;
  logic                            own_tail;
  logic                            out_valid, pop, space, push;

  always_comb begin
    req_sync_d = {req_sync_q[SYNC_STAGES-2:0], bus.req};
    en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], bus.packet_enable};
  end

  assign req_s   = req_sync_q[SYNC_STAGES-1];
  assign en_s    = en_sync_q[SYNC_STAGES-1];
  assign pending = req_s ^ ack_q;

  // Data is only consumed once the owner's request has crossed the
  // synchronizer, which covers the bundled-data delay.
  assign own_flit  = bus.data[owner_q];
  assign own_tail  = own_flit[WIDTH-1];  // types 10 (tail) and 11 (single)

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && bus.out_ready;
  assign space     = (count_q < 2'd2) || pop;
  assign push      = (state_q == StLocked) && pending[owner_q] && space;

  // Round-robin search starting after the last completed owner.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NIN; k++) begin
      idx = IdxW'((last_grant_q + k) % NIN);
      if (!found && en_s[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ack_d        = ack_q;
    tailp_d      = tailp_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          owner_d = grant;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (push) begin
          ack_d[owner_q] = ~ack_q[owner_q];
          if (own_tail) begin
            tailp_d[owner_q] = ~tailp_q[owner_q];
            last_grant_d     = owner_q;
            state_d          = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = own_flit;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_sync_q   <= '0;
      en_sync_q    <= '0;
      state_q      <= StIdle;
      owner_q      <= '0;
      last_grant_q <= IdxW'(NIN - 1);
      ack_q        <= '0;
      tailp_q      <= '0;
      mem_q        <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      req_sync_q   <= req_sync_d;
      en_sync_q    <= en_sync_d;
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      tailp_q      <= tailp_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.tailpassed = tailp_q;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = mem_q[rd_ptr_q];
  assign bus.out_tail   = mem_q[rd_ptr_q][WIDTH-1];

endmodule
